// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data RAM plus MMIO page (LED, switches, timer) for the single-cycle core
// Timer block (TCOUNT/TCMP/TSTAT, TimerIrq) is present only when MMIO_TIMER_EN is defined.
module data_mem_mmio #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0800,
    parameter int          DMEM_DEPTH = 128,
    parameter int          LED_W      = 16,
    parameter int          SW_W       = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             MemWrite,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    input  logic [SW_W-1:0]  Switches,
    output logic [31:0]      ReadData,
    output logic [LED_W-1:0] LED,
    output logic             TimerIrq
);
    localparam int          AW        = $clog2(DMEM_DEPTH);
    localparam logic [31:0] DMEM_END  = DMEM_BASE + 32'(4 * DMEM_DEPTH);
    localparam logic [31:0] ADDR_LED  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_0004;
`ifdef MMIO_TIMER_EN
    localparam logic [31:0] ADDR_TCNT = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_TCMP = 32'hFFFF_000C;
    localparam logic [31:0] ADDR_TST  = 32'hFFFF_0010;
`endif

    logic [31:0]     mem [DMEM_DEPTH];
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic            ram_hit;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     word_addr;

    assign ram_hit   = (ALUResult >= DMEM_BASE) && (ALUResult < DMEM_END);
    assign ram_idx   = AW'((ALUResult - DMEM_BASE) >> 2);
    assign word_addr = {ALUResult[31:2], 2'b00};

    // RAM has no reset; contents are undefined until stored.
    always_ff @(posedge CLK) begin
        if (MemWrite && ram_hit) begin
            mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            LED     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= Switches;
            sw_sync <= sw_meta;
            if (MemWrite && (word_addr == ADDR_LED)) begin
                LED <= WriteData[LED_W-1:0];
            end
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] tcount;
    logic [31:0] tcmp;
    logic        match_flag;
    logic        match;
    logic        clr_req;

    assign match   = (tcmp != 32'h0) && (tcount == tcmp);
    assign clr_req = MemWrite && (word_addr == ADDR_TST) && WriteData[0];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            tcount     <= '0;
            tcmp       <= '0;
            match_flag <= 1'b0;
        end else begin
            tcount <= (MemWrite && (word_addr == ADDR_TCNT)) ? WriteData : tcount + 32'd1;
            if (MemWrite && (word_addr == ADDR_TCMP)) begin
                tcmp <= WriteData;
            end
            // A match set on the same edge as a clear wins.
            if (match) begin
                match_flag <= 1'b1;
            end else if (clr_req) begin
                match_flag <= 1'b0;
            end
        end
    end

    assign TimerIrq = match_flag;
`else
    assign TimerIrq = 1'b0;
`endif

    always_comb begin
        ReadData = 32'h0;
        if (ram_hit) begin
            ReadData = mem[ram_idx];
        end else begin
            case (word_addr)
                ADDR_LED:  ReadData[LED_W-1:0] = LED;
                ADDR_SW:   ReadData[SW_W-1:0]  = sw_sync;
`ifdef MMIO_TIMER_EN
                ADDR_TCNT: ReadData = tcount;
                ADDR_TCMP: ReadData = tcmp;
                ADDR_TST:  ReadData = {31'h0, match_flag};
`endif
                default:   ReadData = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - directed self-checking bench for data_mem_mmio
module tb_data_mem_mmio;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [15:0] Switches;
    logic [31:0] ReadData;
    logic [15:0] LED;
    logic        TimerIrq;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_mmio dut (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .Switches(Switches), .ReadData(ReadData),
        .LED(LED), .TimerIrq(TimerIrq)
    );

    always #5 CLK = ~CLK;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives a store for one edge; pre_rd is ReadData just before that edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] pre_rd);
        ALUResult = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        #1;
        pre_rd = ReadData;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        ALUResult = addr;
        MemWrite  = 1'b0;
        #1;
        data = ReadData;
    endtask

    logic [31:0] rd;
    logic [31:0] pre;

    initial begin
        Reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; Switches = '0;
        tick();
        tick();
        Reset = 1'b0;

        check32("reset_led_port", {16'h0, LED}, 32'h0);
        bus_read(32'hFFFF_0000, rd); check32("reset_led_read", rd, 32'h0);
        bus_read(32'hFFFF_0004, rd); check32("reset_sw_read", rd, 32'h0);
        check32("reset_irq", {31'h0, TimerIrq}, 32'h0);

        // RAM round trip, boundary words, same-cycle old-value read
        bus_write(32'h0000_0800, 32'h1234_5678, pre);
        bus_write(32'h0000_09FC, 32'hDEAD_BEEF, pre);
        bus_read(32'h0000_0800, rd); check32("ram_first", rd, 32'h1234_5678);
        bus_read(32'h0000_09FC, rd); check32("ram_last", rd, 32'hDEAD_BEEF);
        bus_read(32'h0000_0A00, rd); check32("ram_past_end", rd, 32'h0);
        bus_read(32'h0000_07FC, rd); check32("ram_below_base", rd, 32'h0);
        bus_read(32'h0000_0803, rd); check32("ram_low_bits_ignored", rd, 32'h1234_5678);
        bus_write(32'h0000_0A00, 32'hBAD0_BAD0, pre);
        bus_write(32'h0000_07FC, 32'hBAD1_BAD1, pre);
        bus_read(32'h0000_0800, rd); check32("ram_no_alias_first", rd, 32'h1234_5678);
        bus_read(32'h0000_09FC, rd); check32("ram_no_alias_last", rd, 32'hDEAD_BEEF);
        bus_write(32'h0000_0800, 32'hAAAA_5555, pre);
        check32("ram_read_during_write_old", pre, 32'h1234_5678);
        bus_read(32'h0000_0800, rd); check32("ram_overwrite", rd, 32'hAAAA_5555);

        // LED register
        bus_write(32'hFFFF_0000, 32'hFFFF_A5A5, pre);
        check32("led_port", {16'h0, LED}, 32'h0000_A5A5);
        bus_read(32'hFFFF_0000, rd); check32("led_read", rd, 32'h0000_A5A5);
        bus_read(32'hFFFF_0014, rd); check32("unmapped_read", rd, 32'h0);
        Reset = 1'b1;
        bus_write(32'hFFFF_0000, 32'h0000_1111, pre);
        Reset = 1'b0;
        check32("led_reset_over_write", {16'h0, LED}, 32'h0);

        // Switch synchronizer latency
        Switches = 16'h00F0;
        bus_read(32'hFFFF_0004, rd); check32("sw_edge0", rd, 32'h0);
        tick();
        bus_read(32'hFFFF_0004, rd); check32("sw_edge1", rd, 32'h0);
        tick();
        bus_read(32'hFFFF_0004, rd); check32("sw_edge2", rd, 32'h0000_00F0);
        bus_write(32'hFFFF_0004, 32'h0000_0F0F, pre);
        bus_read(32'hFFFF_0004, rd); check32("sw_write_ignored", rd, 32'h0000_00F0);

`ifdef MMIO_TIMER_EN
        bus_write(32'hFFFF_0008, 32'd15, pre);
        bus_read(32'hFFFF_0008, rd); check32("tcnt_load", rd, 32'd15);
        bus_write(32'hFFFF_000C, 32'd20, pre);
        bus_read(32'hFFFF_000C, rd); check32("tcmp_read", rd, 32'd20);
        for (int i = 0; i < 4; i++) tick();
        bus_read(32'hFFFF_0008, rd); check32("tcnt_at_20", rd, 32'd20);
        check32("irq_before_match", {31'h0, TimerIrq}, 32'h0);
        tick();
        check32("irq_on_match", {31'h0, TimerIrq}, 32'h1);
        bus_read(32'hFFFF_0008, rd); check32("tcnt_at_21", rd, 32'd21);
        bus_read(32'hFFFF_0010, rd); check32("tstat_set", rd, 32'h1);
        bus_write(32'hFFFF_0010, 32'h1, pre);
        check32("irq_cleared", {31'h0, TimerIrq}, 32'h0);

        bus_write(32'hFFFF_000C, 32'd40, pre);
        bus_write(32'hFFFF_0008, 32'd39, pre);
        tick();
        check32("irq_pre_match2", {31'h0, TimerIrq}, 32'h0);
        bus_write(32'hFFFF_0010, 32'h1, pre);
        check32("set_wins_over_clear", {31'h0, TimerIrq}, 32'h1);
        bus_write(32'hFFFF_0010, 32'h0, pre);
        bus_read(32'hFFFF_0010, rd); check32("tstat_write0_noeffect", rd, 32'h1);
        bus_write(32'hFFFF_0010, 32'hFFFF_FFFF, pre);
        bus_read(32'hFFFF_0010, rd); check32("tstat_clear_all_ones", rd, 32'h0);

        bus_write(32'hFFFF_0008, 32'hFFFF_FFFE, pre);
        bus_read(32'hFFFF_0008, rd); check32("wrap_fffe", rd, 32'hFFFF_FFFE);
        tick();
        bus_read(32'hFFFF_0008, rd); check32("wrap_ffff", rd, 32'hFFFF_FFFF);
        tick();
        bus_read(32'hFFFF_0008, rd); check32("wrap_zero", rd, 32'h0);
        bus_write(32'hFFFF_0008, 32'h0000_1234, pre);
        bus_read(32'hFFFF_0008, rd); check32("load_no_increment", rd, 32'h0000_1234);

        bus_write(32'hFFFF_000C, 32'h0000_1236, pre);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check32("reset_clears_irq", {31'h0, TimerIrq}, 32'h0);
        bus_read(32'hFFFF_0008, rd); check32("reset_tcnt", rd, 32'h0);
        bus_read(32'hFFFF_000C, rd); check32("reset_tcmp", rd, 32'h0);
`else
        bus_write(32'hFFFF_0008, 32'h0000_0005, pre);
        bus_write(32'hFFFF_000C, 32'h0000_0006, pre);
        bus_write(32'hFFFF_0010, 32'h0000_0001, pre);
        bus_read(32'hFFFF_0008, rd); check32("off_tcnt", rd, 32'h0);
        bus_read(32'hFFFF_000C, rd); check32("off_tcmp", rd, 32'h0);
        bus_read(32'hFFFF_0010, rd); check32("off_tstat", rd, 32'h0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check32("off_irq", {31'h0, TimerIrq}, 32'h0);
        end
`endif

        bus_read(32'h0000_09FC, rd); check32("ram_survives_reset", rd, 32'hDEAD_BEEF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
